// File: rtl/scoreboard_regfile.sv
// Register file with a per-register busy (pending-write) scoreboard, two registered read ports.
// Optional macro SCOREBOARD_REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.

module scoreboard_regfile_cell #(
   parameter int DATA_W    = 32,
   parameter bit HARDWIRED = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv,
   output logic [DATA_W-1:0] data,
   output logic              busy
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         busy <= 1'b0;
      end else begin
         if (wr && !HARDWIRED)
            data <= wr_data;
         // a reserve landing with a write wins: the new producer is still pending
         if (rsv && !HARDWIRED)
            busy <= 1'b1;
         else if (wr)
            busy <= 1'b0;
      end
   end

endmodule

module scoreboard_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rsv_en,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic                   rsv_ack,
   input  logic [ADDR_W-1:0]      rs1_addr,
   input  logic [ADDR_W-1:0]      rs2_addr,
   output logic [DATA_W-1:0]      rd1_data,
   output logic [DATA_W-1:0]      rd2_data,
   output logic                   rd1_busy,
   output logic                   rd2_busy,
   output logic [(1<<ADDR_W)-1:0] busy_vec
);

   localparam int NREGS = 1 << ADDR_W;
   localparam int NPORT = 2;
   localparam bit ZR    = (ZERO_REG != 0);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              busy;
   } rd_rsp_t;

   logic [NREGS-1:0][DATA_W-1:0] regs;
   logic [NREGS-1:0]             busy;
   logic                         rsv_ok;
   logic [NPORT-1:0][ADDR_W-1:0] rs_addr;
   rd_rsp_t [NPORT-1:0]          rd_nxt;
   rd_rsp_t [NPORT-1:0]          rd_q;

   // a busy target is still accepted when the same cycle's write retires it
   assign rsv_ok = rsv_en && (!busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         scoreboard_regfile_cell #(
            .DATA_W    (DATA_W),
            .HARDWIRED (ZR && (gi == 0))
         ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (wr_en && (wr_addr == ADDR_W'(gi))),
            .wr_data (wr_data),
            .rsv     (rsv_ok && (rsv_addr == ADDR_W'(gi))),
            .data    (regs[gi]),
            .busy    (busy[gi])
         );
      end
   endgenerate

   assign rs_addr  = {rs2_addr, rs1_addr};
   assign busy_vec = busy;

   generate
      for (gi = 0; gi < NPORT; gi++) begin : g_port
         always_comb begin
            rd_nxt[gi].data = regs[rs_addr[gi]];
            rd_nxt[gi].busy = busy[rs_addr[gi]];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
            // forward the in-flight write; busy reflects a coincident reserve only
            if (wr_en && (wr_addr == rs_addr[gi]) && !(ZR && (rs_addr[gi] == '0))) begin
               rd_nxt[gi].data = wr_data;
               rd_nxt[gi].busy = rsv_ok && (rsv_addr == rs_addr[gi]);
            end
`endif
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               rd_q[gi] <= '0;
            else
               rd_q[gi] <= rd_nxt[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rsv_ack <= 1'b0;
      else
         rsv_ack <= rsv_ok;
   end

   assign rd1_data = rd_q[0].data;
   assign rd1_busy = rd_q[0].busy;
   assign rd2_data = rd_q[1].data;
   assign rd2_busy = rd_q[1].busy;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: a vector table plus hand sequences for ZERO_REG and async reset.
module tb_scoreboard_regfile;

`ifdef SCOREBOARD_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0, rsv_en = 1'b0;
   logic [3:0]  wr_addr = '0, rsv_addr = '0, rs1_addr = '0, rs2_addr = '0;
   logic [31:0] wr_data = '0;

   logic        ack0, ackz, b1_0, b2_0, b1_z, b2_z;
   logic [31:0] d1_0, d2_0, d1_z, d2_z;
   logic [15:0] bv0, bvz;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scoreboard_regfile #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(ack0),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd1_data(d1_0), .rd2_data(d2_0), .rd1_busy(b1_0), .rd2_busy(b2_0), .busy_vec(bv0));

   scoreboard_regfile #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dutz (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(ackz),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd1_data(d1_z), .rd2_data(d2_z), .rd1_busy(b1_z), .rd2_busy(b2_z), .busy_vec(bvz));

   typedef struct {
      bit          we;
      logic [3:0]  wa;
      logic [31:0] wd;
      bit          re;
      logic [3:0]  ra;
      logic [3:0]  r1, r2;
      bit          ack;
      logic [31:0] d1, d2;
      bit          b1, b2;
      logic [15:0] bv;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                        input bit re, input logic [3:0] ra, input logic [3:0] r1, input logic [3:0] r2);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_en = re; rsv_addr = ra; rs1_addr = r1; rs2_addr = r2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".ack"}, {62'd0, ack0, ackz}, 64'd0);
      chk({nm, ".rd"},  {d1_0, d2_0}, 64'd0);
      chk({nm, ".rdz"}, {d1_z, d2_z}, 64'd0);
      chk({nm, ".bsy"}, {60'd0, b1_0, b2_0, b1_z, b2_z}, 64'd0);
      chk({nm, ".bv"},  {32'd0, bv0, bvz}, 64'd0);
   endtask

   initial begin
      //        we wa  wd            re ra r1  r2   ack d1                         d2                         b1         b2 bv
      vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,  0,   0, 32'h0,                     32'h0,                     0,         0, 16'h0000};
      vt[1]  = '{0, 0, 32'h0,        0, 0, 5,  5,   0, 32'hDEADBEEF,              32'hDEADBEEF,              0,         0, 16'h0000};
      vt[2]  = '{0, 0, 32'h0,        1, 3, 3,  5,   1, 32'h0,                     32'hDEADBEEF,              0,         0, 16'h0008};
      vt[3]  = '{0, 0, 32'h0,        1, 3, 3,  3,   0, 32'h0,                     32'h0,                     1,         1, 16'h0008};
      vt[4]  = '{1, 3, 32'h12,       0, 0, 3,  5,   0, BYP ? 32'h12 : 32'h0,      32'hDEADBEEF,              !BYP,      0, 16'h0000};
      vt[5]  = '{0, 0, 32'h0,        0, 0, 3,  0,   0, 32'h12,                    32'h0,                     0,         0, 16'h0000};
      vt[6]  = '{1, 7, 32'hA5,       1, 7, 7,  0,   1, BYP ? 32'hA5 : 32'h0,      32'h0,                     BYP,       0, 16'h0080};
      vt[7]  = '{0, 0, 32'h0,        0, 0, 7,  7,   0, 32'hA5,                    32'hA5,                    1,         1, 16'h0080};
      vt[8]  = '{1, 2, 32'h11,       0, 0, 0,  0,   0, 32'h0,                     32'h0,                     0,         0, 16'h0080};
      vt[9]  = '{1, 2, 32'h55,       0, 0, 0,  2,   0, 32'h0,                     BYP ? 32'h55 : 32'h11,     0,         0, 16'h0080};
      vt[10] = '{0, 0, 32'h0,        0, 0, 2,  15,  0, 32'h55,                    32'h0,                     0,         0, 16'h0080};
      vt[11] = '{0, 0, 32'h0,        1, 7, 7,  15,  0, 32'hA5,                    32'h0,                     1,         0, 16'h0080};
      vt[12] = '{1, 15, 32'hCAFEF00D,1, 9, 7,  9,   1, 32'hA5,                    32'h0,                     1,         0, 16'h0280};
      vt[13] = '{1, 7, 32'h77,       1, 7, 15, 9,   1, 32'hCAFEF00D,              32'h0,                     0,         1, 16'h0280};
      vt[14] = '{0, 0, 32'h0,        0, 0, 7,  7,   0, 32'h77,                    32'h77,                    1,         1, 16'h0280};

      // async reset asserted before any clock edge
      #1 rst_n = 1'b0;
      #2 chk_zero("por");
      step();
      step();
      rst_n = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, vt[i].r1, vt[i].r2);
         step();
         chk($sformatf("v%0d.ack", i), {63'd0, ack0}, {63'd0, vt[i].ack});
         chk($sformatf("v%0d.rd1", i), {32'd0, d1_0}, {32'd0, vt[i].d1});
         chk($sformatf("v%0d.rd2", i), {32'd0, d2_0}, {32'd0, vt[i].d2});
         chk($sformatf("v%0d.bsy", i), {62'd0, b1_0, b2_0}, {62'd0, vt[i].b1, vt[i].b2});
         chk($sformatf("v%0d.bv", i),  {48'd0, bv0}, {48'd0, vt[i].bv});
      end

      // ZERO_REG: write and reserve r0 together
      drive(1, 0, 32'hFFFF, 1, 0, 0, 0);
      step();
      chk("z.ack", {62'd0, ackz, ack0}, {62'd0, 1'b1, 1'b1});
      chk("z.bv0", {62'd0, bvz[0], bv0[0]}, {62'd0, 1'b0, 1'b1});
      chk("z.bvz", {48'd0, bvz}, 64'h0280);
      chk("z.rd1", {31'd0, b1_z, d1_z}, 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("z.rd1z", {31'd0, b1_z, d1_z}, 64'd0);
      chk("z.rd1n", {31'd0, b1_0, d1_0}, {31'd0, 1'b1, 32'hFFFF});

      // reserve r4, then assert reset mid-cycle with a write and reserve pending
      drive(0, 0, 0, 1, 4, 5, 4);
      step();
      chk("r.ack", {62'd0, ack0, ackz}, {62'd0, 1'b1, 1'b1});
      chk("r.bv",  {32'd0, bv0, bvz}, {32'd0, 16'h0291, 16'h0290});
      drive(1, 5, 32'h1, 1, 6, 5, 4);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_mid");
      step();
      chk_zero("rst_hold");
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 5, 4);
      step();
      chk_zero("rst_post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
